// File: rtl/fsb_trace_pkg.sv
// Shared definitions for the FSB trace packer: beat header layout and packer states.
package fsb_trace_pkg;

  localparam int unsigned slots_lp   = 6;
  localparam int unsigned cnt_lsb_lp = 480;
  localparam int unsigned seq_lsb_lp = 488;

  typedef struct packed {
    logic [23:0] seq;
    logic [7:0]  cnt;
  } trace_beat_hdr_s;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2
  } packer_state_e;

  function automatic trace_beat_hdr_s make_hdr(input logic [23:0] seq, input logic [7:0] cnt);
    trace_beat_hdr_s h;
    h.seq = seq;
    h.cnt = cnt;
    return h;
  endfunction

endpackage

// File: rtl/bsg_one_fifo.sv
// Single-entry output buffer; a new entry may be enqueued in the same cycle the held one drains.
module bsg_one_fifo #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic               full_q, full_d;
  logic [width_p-1:0] data_q, data_d;

  assign ready_o = ~full_q | yumi_i;
  assign v_o     = full_q;
  assign data_o  = data_q;

  // Next-state for occupancy and payload.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (v_i && ready_o) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (yumi_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Storage registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fsb_trace_packer.sv
// Packs 80-bit FSB trace words six per 512-bit AXI-Stream beat with a count/sequence header;
// packets close on a fixed beat count, an idle timeout, or an explicit flush.
module fsb_trace_packer
  import fsb_trace_pkg::*;
#(
  parameter int fsb_width_p     = 80,
  parameter int axis_width_p    = 512,
  parameter int beats_per_pkt_p = 8,
  parameter int flush_timeout_p = 256
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic                      v_i,
  input  logic [fsb_width_p-1:0]    data_i,
  output logic                      ready_o,
  output logic                      txd_tvalid_o,
  output logic [axis_width_p-1:0]   txd_tdata_o,
  output logic [axis_width_p/8-1:0] txd_tkeep_o,
  output logic                      txd_tlast_o,
  input  logic                      txd_tready_i,
  output logic [31:0]               beats_sent_o
);

  localparam int num_slots_lp  = axis_width_p / fsb_width_p;
  localparam int pack_width_lp = num_slots_lp * fsb_width_p;
  localparam int slot_w_lp     = $clog2(num_slots_lp + 1);
  localparam int idle_w_lp     = $clog2(flush_timeout_p + 1);
  localparam int pkt_w_lp      = (beats_per_pkt_p > 1) ? $clog2(beats_per_pkt_p) : 1;

  packer_state_e state_q, state_d;
  logic [pack_width_lp-1:0] pack_q, pack_d, merged_s, beat_pack_s;
  logic [slot_w_lp-1:0]     slot_q, slot_d, fill_cnt_s, beat_cnt_s;
  logic [idle_w_lp-1:0]     idle_q, idle_d;
  logic [pkt_w_lp-1:0]      pkt_q, pkt_d, pkt_after_load_s;
  logic                     hold_last_q, hold_last_d;
  logic [23:0]              seq_q;
  logic [31:0]              sent_q;

  logic accept_s, handoff_s, timeout_s, full_s, close_s, close_last_s;
  logic load_s, beat_reason_s, beat_last_s, out_ready_s, out_v_s;
  logic [axis_width_p:0]   out_data_s, load_data_s;
  logic [axis_width_p-1:0] tdata_s;
  trace_beat_hdr_s         hdr_s;

  assign ready_o      = en_i & ~reset_i & (state_q != HOLD);
  assign accept_s     = v_i & ready_o;
  assign handoff_s    = out_v_s & txd_tready_i;
  assign timeout_s    = (state_q == FILL) && (idle_q == idle_w_lp'(flush_timeout_p));
  assign full_s       = accept_s && (slot_q == slot_w_lp'(num_slots_lp - 1));
  assign fill_cnt_s   = slot_q + slot_w_lp'(accept_s);
  assign close_last_s = timeout_s | flush_i;
  // A flush in EMPTY only closes a beat if it carries a word with it.
  assign close_s      = (state_q != HOLD) && ((state_q == FILL) || accept_s)
                        && (full_s || timeout_s || flush_i);

  assign beat_pack_s      = (state_q == HOLD) ? pack_q : merged_s;
  assign beat_cnt_s       = (state_q == HOLD) ? slot_q : fill_cnt_s;
  assign beat_reason_s    = (state_q == HOLD) ? (hold_last_q | flush_i) : close_last_s;
  assign beat_last_s      = (pkt_q == pkt_w_lp'(beats_per_pkt_p - 1)) | beat_reason_s;
  assign pkt_after_load_s = beat_last_s ? '0 : pkt_q + pkt_w_lp'(1);

  // Pack register with the incoming word dropped into the current slot.
  always_comb begin
    merged_s = pack_q;
    for (int k = 0; k < num_slots_lp; k++) begin
      if (accept_s && (slot_q == slot_w_lp'(k))) begin
        merged_s[k*fsb_width_p +: fsb_width_p] = data_i;
      end else begin
        merged_s[k*fsb_width_p +: fsb_width_p] = pack_q[k*fsb_width_p +: fsb_width_p];
      end
    end
  end

  // Packer FSM: fill, close, and hand the beat to the output register.
  always_comb begin
    state_d     = state_q;
    pack_d      = pack_q;
    slot_d      = slot_q;
    idle_d      = idle_q;
    pkt_d       = pkt_q;
    hold_last_d = hold_last_q;
    load_s      = 1'b0;
    case (state_q)
      EMPTY, FILL: begin
        if (close_s) begin
          idle_d = '0;
          if (out_ready_s) begin
            load_s      = 1'b1;
            state_d     = EMPTY;
            pack_d      = '0;
            slot_d      = '0;
            hold_last_d = 1'b0;
            pkt_d       = pkt_after_load_s;
          end else begin
            state_d     = HOLD;
            pack_d      = merged_s;
            slot_d      = fill_cnt_s;
            hold_last_d = close_last_s;
          end
        end else if (accept_s) begin
          state_d = FILL;
          pack_d  = merged_s;
          slot_d  = fill_cnt_s;
          idle_d  = '0;
        end else if (state_q == FILL) begin
          idle_d = (idle_q == idle_w_lp'(flush_timeout_p)) ? idle_q : idle_q + idle_w_lp'(1);
        end else begin
          // Idle flush in EMPTY: nothing to emit, but the next beat opens a new packet.
          idle_d = '0;
          pkt_d  = flush_i ? '0 : pkt_q;
        end
      end
      HOLD: begin
        hold_last_d = hold_last_q | flush_i;
        if (out_ready_s) begin
          load_s      = 1'b1;
          state_d     = EMPTY;
          pack_d      = '0;
          slot_d      = '0;
          hold_last_d = 1'b0;
          pkt_d       = pkt_after_load_s;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A beat loaded while the previous one drains takes the following sequence number.
  assign hdr_s = make_hdr(seq_q + 24'(handoff_s), 8'(beat_cnt_s));

  // Beat assembly: slots in the low bits, header on top.
  always_comb begin
    tdata_s                          = '0;
    tdata_s[pack_width_lp-1:0]       = beat_pack_s;
    tdata_s[cnt_lsb_lp +: 32]        = hdr_s;
  end

  assign load_data_s = {beat_last_s, tdata_s};

  bsg_one_fifo #(.width_p(axis_width_p + 1)) out_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (out_ready_s),
    .v_i     (load_s),
    .data_i  (load_data_s),
    .v_o     (out_v_s),
    .data_o  (out_data_s),
    .yumi_i  (handoff_s)
  );

  assign txd_tvalid_o = out_v_s;
  assign txd_tdata_o  = out_data_s[axis_width_p-1:0];
  assign txd_tlast_o  = out_data_s[axis_width_p];
  assign txd_tkeep_o  = '1;
  assign beats_sent_o = sent_q;

  // State, pack storage and counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= EMPTY;
      pack_q      <= '0;
      slot_q      <= '0;
      idle_q      <= '0;
      pkt_q       <= '0;
      hold_last_q <= 1'b0;
      seq_q       <= 24'd0;
      sent_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      pack_q      <= pack_d;
      slot_q      <= slot_d;
      idle_q      <= idle_d;
      pkt_q       <= pkt_d;
      hold_last_q <= hold_last_d;
      seq_q       <= seq_q + 24'(handoff_s);
      sent_q      <= sent_q + 32'(handoff_s);
    end
  end

endmodule
